// File: rtl/dmac_axi_mem_pkg.sv
// Shared constants and state types for the DMAC AXI3 slave memory.
// Burst/response encodings follow AXI3.
package dmac_axi_mem_pkg;

  localparam logic [1:0] FIXED   = 2'b00;
  localparam logic [1:0] INCR    = 2'b01;
  localparam logic [1:0] OKAY    = 2'b00;
  localparam logic [1:0] SLVERR  = 2'b10;
  localparam logic [2:0] SIZE_4B = 3'b010;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  function automatic logic legal_req(
    input logic [1:0] burst,
    input logic [2:0] size
  );
    return (burst == INCR) && (size == SIZE_4B);
  endfunction

endpackage

// File: rtl/dmac_axi_mem_array.sv
// Word array with a byte-enable write port and a registered read port.
// A same-cycle read of the word being written returns the old contents.
module dmac_axi_mem_array #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  input  logic          re,
  input  logic          rzero,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Contents are never reset; only the output register is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rzero ? '0 : mem[raddr];
    end
  end

endmodule

// File: rtl/dmac_axi_mem_slave.sv
// AXI3 slave memory: one read and one write burst in flight at once,
// independent FSMs over a shared byte-writable array.
module dmac_axi_mem_slave
  import dmac_axi_mem_pkg::*;
#(
  parameter int         MEM_AW    = 16,
  parameter int         ID_W      = 4,
  parameter int         BP_EN     = 0,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ID_W-1:0] awid_i,
  input  logic [31:0]     awaddr_i,
  input  logic [3:0]      awlen_i,
  input  logic [2:0]      awsize_i,
  input  logic [1:0]      awburst_i,
  input  logic            awvalid_i,
  output logic            awready_o,
  input  logic [ID_W-1:0] wid_i,
  input  logic [31:0]     wdata_i,
  input  logic [3:0]      wstrb_i,
  input  logic            wlast_i,
  input  logic            wvalid_i,
  output logic            wready_o,
  output logic [ID_W-1:0] bid_o,
  output logic [1:0]      bresp_o,
  output logic            bvalid_o,
  input  logic            bready_i,
  input  logic [ID_W-1:0] arid_i,
  input  logic [31:0]     araddr_i,
  input  logic [3:0]      arlen_i,
  input  logic [2:0]      arsize_i,
  input  logic [1:0]      arburst_i,
  input  logic            arvalid_i,
  output logic            arready_o,
  output logic [ID_W-1:0] rid_o,
  output logic [31:0]     rdata_o,
  output logic [1:0]      rresp_o,
  output logic            rlast_o,
  output logic            rvalid_o,
  input  logic            rready_i
);

  localparam int WA = MEM_AW - 2;

  logic [7:0] lfsr;
  logic       gate;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign gate = (BP_EN != 0) ? lfsr[0] : 1'b1;

  wr_state_t       w_st;
  logic [WA-1:0]   w_addr;
  logic [ID_W-1:0] w_id;
  logic [3:0]      w_len;
  logic [3:0]      w_beat;
  logic            w_err;
  logic            w_perr;
  logic            aw_hs;
  logic            w_hs;
  logic            w_final;
  logic            w_bad;

  assign awready_o = (w_st == W_IDLE) & gate;
  assign wready_o  = (w_st == W_DATA) & gate;
  assign aw_hs     = awvalid_i & awready_o;
  assign w_hs      = wvalid_i & wready_o;
  assign w_final   = (w_beat == w_len);
  assign w_bad     = (wlast_i != w_final);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_st     <= W_IDLE;
      w_addr   <= '0;
      w_id     <= '0;
      w_len    <= '0;
      w_beat   <= '0;
      w_err    <= 1'b0;
      w_perr   <= 1'b0;
      bvalid_o <= 1'b0;
      bid_o    <= '0;
      bresp_o  <= OKAY;
    end else begin
      unique case (w_st)
        W_IDLE: if (aw_hs) begin
          w_id   <= awid_i;
          w_addr <= awaddr_i[MEM_AW-1:2];
          w_len  <= awlen_i;
          w_beat <= '0;
          w_err  <= !legal_req(awburst_i, awsize_i);
          w_perr <= 1'b0;
          w_st   <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          w_addr <= w_addr + 1'b1;
          w_beat <= w_beat + 4'd1;
          w_perr <= w_perr | w_bad;
          if (w_final) begin
            bvalid_o <= 1'b1;
            bid_o    <= w_id;
            bresp_o  <= (w_err | w_perr | w_bad) ? SLVERR : OKAY;
            w_st     <= W_RESP;
          end
        end
        W_RESP: if (bready_i) begin
          bvalid_o <= 1'b0;
          w_st     <= W_IDLE;
        end
        default: w_st <= W_IDLE;
      endcase
    end
  end

  rd_state_t     r_st;
  logic [WA-1:0] r_addr;
  logic [3:0]    r_len;
  logic [3:0]    r_beat;
  logic          r_err;
  logic          ar_hs;
  logic          r_hs;
  logic          r_final;
  logic          ar_ok;

  assign arready_o = (r_st == R_IDLE) & gate;
  assign ar_hs     = arvalid_i & arready_o;
  assign r_hs      = rvalid_o & rready_i;
  assign r_final   = (r_beat == r_len);
  assign ar_ok     = legal_req(arburst_i, arsize_i);

  // r_addr always points at the word to prefetch on the next beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st     <= R_IDLE;
      r_addr   <= '0;
      r_len    <= '0;
      r_beat   <= '0;
      r_err    <= 1'b0;
      rvalid_o <= 1'b0;
      rlast_o  <= 1'b0;
      rresp_o  <= OKAY;
      rid_o    <= '0;
    end else begin
      unique case (r_st)
        R_IDLE: if (ar_hs) begin
          rid_o    <= arid_i;
          r_addr   <= araddr_i[MEM_AW-1:2] + 1'b1;
          r_len    <= arlen_i;
          r_beat   <= '0;
          r_err    <= !ar_ok;
          rvalid_o <= 1'b1;
          rlast_o  <= (arlen_i == 4'd0);
          rresp_o  <= ar_ok ? OKAY : SLVERR;
          r_st     <= R_DATA;
        end
        R_DATA: if (r_hs) begin
          if (r_final) begin
            rvalid_o <= 1'b0;
            rlast_o  <= 1'b0;
            r_st     <= R_IDLE;
          end else begin
            r_beat  <= r_beat + 4'd1;
            r_addr  <= r_addr + 1'b1;
            rlast_o <= ((r_beat + 4'd1) == r_len);
          end
        end
        default: r_st <= R_IDLE;
      endcase
    end
  end

  logic          rd_re;
  logic          rd_zero;
  logic [WA-1:0] rd_addr;

  assign rd_re   = ar_hs | (r_hs & ~r_final);
  assign rd_addr = ar_hs ? araddr_i[MEM_AW-1:2] : r_addr;
  assign rd_zero = ar_hs ? ~ar_ok : r_err;

  dmac_axi_mem_array #(
    .AW (WA)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_hs & ~w_err),
    .waddr (w_addr),
    .wdata (wdata_i),
    .wstrb (wstrb_i),
    .re    (rd_re),
    .rzero (rd_zero),
    .raddr (rd_addr),
    .rdata (rdata_o)
  );

  logic unused_bits;
  assign unused_bits = ^{wid_i, awaddr_i[31:MEM_AW], awaddr_i[1:0],
                         araddr_i[31:MEM_AW], araddr_i[1:0]};

endmodule

// File: tb/tb_dmac_axi_mem_slave.sv
// Randomized bench for dmac_axi_mem_slave against a timestamped
// write-log memory model.
module tb_dmac_axi_mem_slave;
  import dmac_axi_mem_pkg::*;

  localparam int DEPTH = 1 << 14;
  localparam int MAXW  = 500;

  logic        clk = 0;
  logic        rst_n = 0;
  logic [3:0]  awid_i = 0, wid_i = 0, arid_i = 0;
  logic [31:0] awaddr_i = 0, araddr_i = 0, wdata_i = 0;
  logic [3:0]  awlen_i = 0, arlen_i = 0, wstrb_i = 0;
  logic [2:0]  awsize_i = 0, arsize_i = 0;
  logic [1:0]  awburst_i = 0, arburst_i = 0;
  logic        awvalid_i = 0, wlast_i = 0, wvalid_i = 0;
  logic        bready_i = 0, arvalid_i = 0, rready_i = 0;
  logic        awready_o, wready_o, bvalid_o, arready_o;
  logic        rlast_o, rvalid_o;
  logic [3:0]  bid_o, rid_o;
  logic [1:0]  bresp_o, rresp_o;
  logic [31:0] rdata_o;

  dmac_axi_mem_slave #(
    .MEM_AW(16), .ID_W(4), .BP_EN(1), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i),
    .awsize_i(awsize_i), .awburst_i(awburst_i),
    .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
    .wlast_i(wlast_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o),
    .bready_i(bready_i),
    .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i),
    .arsize_i(arsize_i), .arburst_i(arburst_i),
    .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o),
    .rlast_o(rlast_o), .rvalid_o(rvalid_o), .rready_i(rready_i)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] lfsr_m;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= 8'hA5;
    else lfsr_m <= {lfsr_m[6:0],
                    lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  typedef struct {
    longint      t;
    int          idx;
    logic [31:0] val;
    bit          known;
  } wlog_t;

  wlog_t wlog[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bail(input string tag);
    n_cmp++;
    n_err++;
    $display("FAIL %s timeout", tag);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  endtask

  // Value of word w as seen by an array read issued at time t.
  function automatic bit lookup(input int w, input longint t,
                                output logic [31:0] v);
    for (int i = wlog.size() - 1; i >= 0; i--) begin
      if (wlog[i].idx == w && wlog[i].t < t) begin
        v = wlog[i].val;
        return wlog[i].known;
      end
    end
    v = '0;
    return 1'b0;
  endfunction

  function automatic int widx(input logic [31:0] a, input int k);
    return (int'(a[15:2]) + k) % DEPTH;
  endfunction

  task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr,
                          input int len, input logic [1:0] burst,
                          input logic [2:0] size, input int last_bad,
                          input logic [31:0] d0, input logic [31:0] dstep,
                          input logic [3:0] s0, input bit rnd);
    logic [31:0] d, cur, nv;
    logic [3:0]  s;
    bit          legal, perr, kn;
    int          n, w;
    legal = (burst == INCR) && (size == SIZE_4B);
    perr  = (last_bad >= 0) && (last_bad != len);
    awid_i = id; awaddr_i = addr; awlen_i = 4'(len);
    awburst_i = burst; awsize_i = size; awvalid_i = 1;
    n = 0;
    while (!awready_o) begin
      @(negedge clk);
      if (++n > MAXW) bail("tmo_aw");
    end
    @(negedge clk);
    awvalid_i = 0;
    for (int k = 0; k <= len; k++) begin
      d = rnd ? $urandom : d0 + dstep * k;
      s = rnd ? 4'($urandom_range(0, 15)) : s0;
      wdata_i = d; wstrb_i = s; wid_i = id;
      wlast_i = (last_bad >= 0) ? (k == last_bad) : (k == len);
      wvalid_i = 1;
      n = 0;
      while (!wready_o) begin
        @(negedge clk);
        if (++n > MAXW) bail("tmo_w");
      end
      if (legal) begin
        w = widx(addr, k);
        kn = lookup(w, 64'h7fffffffffffffff, cur);
        nv = cur;
        for (int b = 0; b < 4; b++) if (s[b]) nv[8*b +: 8] = d[8*b +: 8];
        wlog.push_back('{cyc, w, nv, !perr && (kn || s == 4'hF)});
      end
      @(negedge clk);
    end
    wvalid_i = 0; wlast_i = 0;
    n = 0;
    forever begin
      bready_i = 1'($urandom_range(0, 1));
      if (bvalid_o && bready_i) break;
      @(negedge clk);
      if (++n > MAXW) bail("tmo_b");
    end
    chk("bid", {28'd0, bid_o}, {28'd0, id});
    chk("bresp", {30'd0, bresp_o}, (legal && !perr) ? 32'd0 : 32'd2);
    @(negedge clk);
    bready_i = 0;
  endtask

  task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr,
                          input int len, input logic [1:0] burst,
                          input logic [2:0] size, input int stall_beat);
    longint      tl;
    logic [31:0] ev;
    bit          legal, kn;
    int          k, n, st;
    legal = (burst == INCR) && (size == SIZE_4B);
    arid_i = id; araddr_i = addr; arlen_i = 4'(len);
    arburst_i = burst; arsize_i = size; arvalid_i = 1;
    n = 0;
    while (!arready_o) begin
      @(negedge clk);
      if (++n > MAXW) bail("tmo_ar");
    end
    tl = cyc;
    @(negedge clk);
    arvalid_i = 0;
    chk("rvalid_lat", {31'd0, rvalid_o}, 32'd1);
    k = 0; st = 0; n = 0;
    while (k <= len) begin
      if (k == stall_beat && st < 5) begin
        rready_i = 0;
        st++;
      end else begin
        rready_i = ($urandom_range(0, 3) != 0);
      end
      chk("rvalid", {31'd0, rvalid_o}, 32'd1);
      if (legal) kn = lookup(widx(addr, k), tl, ev);
      else begin kn = 1; ev = 0; end
      if (kn) chk("rdata", rdata_o, ev);
      chk("rlast", {31'd0, rlast_o}, {31'd0, k == len});
      chk("rid", {28'd0, rid_o}, {28'd0, id});
      chk("rresp", {30'd0, rresp_o}, legal ? 32'd0 : 32'd2);
      if (rvalid_o && rready_i) begin
        tl = cyc;
        k++;
      end
      @(negedge clk);
      if (++n > MAXW) bail("tmo_r");
    end
    rready_i = 0;
    chk("rvalid_end", {31'd0, rvalid_o}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, wa;
    logic [1:0]  rb, wb;
    logic [2:0]  rs, ws;
    int          rl, wl, lb, r, n;

    repeat (3) @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_awready", {31'd0, awready_o}, 32'd1);
    chk("rst_arready", {31'd0, arready_o}, 32'd1);
    chk("rst_bvalid", {31'd0, bvalid_o}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
    chk("rst_wready", {31'd0, wready_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("lfsr_aw", {31'd0, awready_o}, {31'd0, lfsr_m[0]});
      chk("lfsr_ar", {31'd0, arready_o}, {31'd0, lfsr_m[0]});
    end

    wr_burst(3, 32'h1000, 3, INCR, SIZE_4B, -1,
             32'h11111111, 32'h11111111, 4'hF, 0);
    rd_burst(5, 32'h1000, 3, INCR, SIZE_4B, -1);

    wr_burst(1, 32'h2000, 0, INCR, SIZE_4B, -1, 32'hFFFFFFFF, 0, 4'hF, 0);
    wr_burst(2, 32'h2000, 0, INCR, SIZE_4B, -1, 32'h12345678, 0, 4'h5, 0);
    rd_burst(6, 32'h2000, 0, INCR, SIZE_4B, -1);

    wr_burst(4, 32'h3000, 7, INCR, SIZE_4B, -1, 0, 0, 4'hF, 1);
    rd_burst(7, 32'h3000, 7, INCR, SIZE_4B, 3);

    wr_burst(7, 32'h1000, 3, FIXED, SIZE_4B, -1, 0, 0, 4'hF, 1);
    rd_burst(8, 32'h1000, 3, INCR, SIZE_4B, -1);
    rd_burst(9, 32'h1000, 3, INCR, 3'b001, -1);

    wr_burst(10, 32'h6000, 3, INCR, SIZE_4B, 2, 0, 0, 4'hF, 1);

    wr_burst(11, 32'h4000, 3, INCR, SIZE_4B, -1,
             32'hA0A0A0A0, 32'h01010101, 4'hF, 0);
    fork
      wr_burst(12, 32'h4000, 3, INCR, SIZE_4B, -1, 0, 0, 4'hF, 1);
      rd_burst(13, 32'h4000, 3, INCR, SIZE_4B, -1);
    join

    for (int it = 0; it < 40; it++) begin
      r  = $urandom_range(0, 2);
      wa = (r == 0) ? 32'h4000 : (r == 1) ? 32'h4010 : 32'hFFF0;
      wa = wa | ($urandom & 32'hFFFF0000);
      r  = $urandom_range(0, 2);
      ra = (r == 0) ? 32'h4000 : (r == 1) ? 32'h4010 : 32'hFFF0;
      ra = ra | ($urandom & 32'hFFFF0000);
      wl = $urandom_range(0, 7);
      rl = $urandom_range(0, 7);
      r  = $urandom_range(0, 9);
      wb = (r == 0) ? FIXED : (r == 1) ? 2'b10 : INCR;
      ws = (r == 2) ? 3'b001 : SIZE_4B;
      r  = $urandom_range(0, 9);
      rb = (r == 0) ? FIXED : INCR;
      rs = (r == 1) ? 3'b000 : SIZE_4B;
      lb = ($urandom_range(0, 7) == 0) ? $urandom_range(0, wl) : -1;
      fork
        wr_burst(4'($urandom), wa, wl, wb, ws, lb, 0, 0, 4'hF, 1);
        rd_burst(4'($urandom), ra, rl, rb, rs, -1);
      join
    end

    @(negedge clk);
    arid_i = 9; araddr_i = 32'h1000; arlen_i = 7;
    arburst_i = INCR; arsize_i = SIZE_4B; arvalid_i = 1;
    n = 0;
    while (!rvalid_o) begin
      @(negedge clk);
      if (++n > MAXW) bail("tmo_rst");
    end
    arvalid_i = 0;
    #2 rst_n = 0;
    #1;
    chk("mid_rvalid", {31'd0, rvalid_o}, 32'd0);
    chk("mid_rlast", {31'd0, rlast_o}, 32'd0);
    chk("mid_rdata", rdata_o, 32'd0);
    chk("mid_rid", {28'd0, rid_o}, 32'd0);
    chk("mid_arready", {31'd0, arready_o}, 32'd1);
    @(negedge clk);
    rst_n = 1;
    rd_burst(5, 32'h1000, 3, INCR, SIZE_4B, -1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmac_axi_mem_slave.md
Name: dmac_axi_mem_slave

Overview:
Synthesizable AXI3 slave memory; the responder end of the DMAC's AXI master interface (AW/W/B/AR/R).
Serves one outstanding read burst and one outstanding write burst concurrently, with independent read and write FSMs over a shared byte-writable array.
Used for gate-level and FPGA bring-up of DMAC_TOP in place of the behavioural memory model.
Optional LFSR-driven ready throttling exercises DMAC back-pressure handling.

Parameters:
MEM_AW, 16, byte-address bits decoded; array depth = 2^(MEM_AW-2) 32-bit words
ID_W, 4, AXI ID width
BP_EN, 0, 1 = pseudo-random throttling of awready_o/wready_o/arready_o
LFSR_SEED, 8'hA5, non-zero seed of the 8-bit throttling LFSR

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
awid_i in ID_W; awaddr_i in 32; awlen_i in 4; awsize_i in 3; awburst_i in 2; awvalid_i in 1; awready_o out 1  AW channel
wid_i in ID_W; wdata_i in 32; wstrb_i in 4; wlast_i in 1; wvalid_i in 1; wready_o out 1  W channel
bid_o out ID_W; bresp_o out 2; bvalid_o out 1; bready_i in 1  B channel
arid_i in ID_W; araddr_i in 32; arlen_i in 4; arsize_i in 3; arburst_i in 2; arvalid_i in 1; arready_o out 1  AR channel
rid_o out ID_W; rdata_o out 32; rresp_o out 2; rlast_o out 1; rvalid_o out 1; rready_i in 1  R channel

Behaviour:
- Reset (async, any time, including mid-burst): both FSMs go to IDLE; awready_o=arready_o=1 (gated by LFSR when BP_EN=1); wready_o, bvalid_o, rvalid_o, rlast_o = 0; bresp_o, rresp_o, bid_o, rid_o, rdata_o = 0. Array contents are not reset; any burst in flight is abandoned.
- Addressing: word index = addr[MEM_AW-1:2]; upper bits ignored (aliasing); addr[1:0] ignored. Burst address increments by 1 word per beat and wraps modulo the array depth.
- Legal request: burst = INCR (2'b01) and size = 3'b010. Anything else is an error burst: beats are still fully handshaked, no array write occurs, rdata_o=0, and resp = SLVERR (2'b10).
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready_o=1. On the AW handshake, latch id, word address and len, set beat count = 0, go to W_DATA.
  - W_DATA: wready_o=1. Each wvalid&wready beat writes the bytes enabled by wstrb_i and increments the address and beat count.
  - On beat count == len, go to W_RESP.
  - Protocol error (SLVERR): wlast_i low on the final beat, or wlast_i high on an earlier beat. The burst always runs len+1 beats.
  - W_RESP: bvalid_o=1, bid_o = latched id. Hold until bready_i, then go to W_IDLE; awready_o returns on the next cycle.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready_o=1. On the AR handshake, latch id and len; rdata_o is loaded from the array at the AR address. rvalid_o=1 on the next cycle (1-cycle latency).
  - R_DATA: rid_o = latched id; rlast_o=1 only on beat == len.
  - On rvalid&rready, load the next word into rdata_o (registered prefetch, zero bubbles between beats).
  - While rready_i is low, rdata_o, rresp_o and rlast_o are held stable.
  - After the last beat: rvalid_o=0, go to R_IDLE.
- Same-cycle array read and write to the same word: the read returns the old value (read-before-write).
- BP_EN=1: the 8-bit Fibonacci LFSR (taps 8,6,5,4) advances every cycle. awready_o, wready_o and arready_o are ANDed with LFSR bit0. valid signals are never throttled, and a valid is never dropped before its handshake.
- WID is ignored (no write interleaving).

Decomposition:
- Package dmac_axi_mem_pkg:
  - burst constants: FIXED=2'b00, INCR=2'b01
  - resp constants: OKAY=2'b00, SLVERR=2'b10
  - SIZE_4B = 3'b010
  - wr_state_t and rd_state_t enums
- Sub-module dmac_axi_mem_array: 2^(MEM_AW-2) x 32 storage with one byte-enable write port and one synchronous read port (read-before-write).

Test Plan:
- Reset release -> awready_o=arready_o=1 and bvalid_o=rvalid_o=0 on the first cycle after reset.
- AW 0x1000 id=3 len=3 with data 0x11111111..0x44444444, wstrb 4'hF -> bvalid_o with bid_o=3 and bresp_o=0. AR 0x1000 id=5 len=3 -> the same 4 words, rid_o=5, rlast_o on the 4th beat only, rresp_o=0.
- Word 0x2000 holds 0xFFFFFFFF; write 0x12345678 with wstrb 4'b0101 -> readback 0xFF34FF78.
- AR len=7 with rready_i low for 5 cycles after beat 2 -> rdata_o/rlast_o stable throughout the stall, all 8 beats in order, no beat lost or repeated.
- AW with awburst=2'b00 -> 4 beats accepted, bresp_o=2'b10, memory unchanged. AR with arsize=3'b001 -> every beat rresp_o=2'b10, rdata_o=0.
- AW len=3 with wlast_i on beat 2 -> 4 beats accepted, bresp_o=2'b10.
- Concurrent R and W bursts to the same word with BP_EN=1 -> both complete, and the read beat coincident with the write returns the old value.
